// File: rtl/queue_pkg.sv
// Shared types and constants for the bank-queue counter path.
// Used by the conditioner, counter and flags stages.
package queue_pkg;

  localparam int DEBOUNCE_DEFAULT = 16;
  localparam int QUEUE_DEPTH = 16;

  typedef enum logic [1:0] {
    RELEASED,
    ARMING,
    PRESSED,
    DISARMING
  } btn_state_e;

endpackage

// File: rtl/debounce_ch.sv
// One debounce channel: 2-flop synchroniser, stability counter, FSM.
// rise is combinational from flops only and is registered by the caller.
module debounce_ch
  import queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic lvl,
  output logic rise
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [1:0]       sync_q;
  logic             smp;
  logic             done;
  logic             lvl_q;
  logic [CNT_W-1:0] cnt_q;
  btn_state_e       state_q;

  assign smp  = sync_q[1];
  assign done = (cnt_q == LAST);
  assign lvl  = lvl_q;
  assign rise = (state_q == ARMING) && smp && done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q  <= '0;
      cnt_q   <= '0;
      lvl_q   <= 1'b0;
      state_q <= RELEASED;
    end else begin
      sync_q <= {sync_q[0], raw};
      unique case (state_q)
        RELEASED: begin
          cnt_q <= smp ? CNT_W'(1) : '0;
          if (smp) state_q <= ARMING;
        end
        ARMING: begin
          if (!smp) begin
            cnt_q   <= '0;
            state_q <= RELEASED;
          end else if (done) begin
            cnt_q   <= '0;
            lvl_q   <= 1'b1;
            state_q <= PRESSED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PRESSED: begin
          cnt_q <= !smp ? CNT_W'(1) : '0;
          if (!smp) state_q <= DISARMING;
        end
        DISARMING: begin
          if (smp) begin
            cnt_q   <= '0;
            state_q <= PRESSED;
          end else if (done) begin
            cnt_q   <= '0;
            lvl_q   <= 1'b0;
            state_q <= RELEASED;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RELEASED;
      endcase
    end
  end

endmodule

// File: rtl/queue_event_conditioner.sv
// Turns raw push/updown into single-cycle inc/dec/reject requests,
// blocking presses that would overflow or underflow the queue.
module queue_event_conditioner
  import queue_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT,
  parameter int CNT_W = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic updown,
  input  logic full,
  input  logic empty,
  output logic inc_pulse,
  output logic dec_pulse,
  output logic reject,
  output logic btn_level,
  output logic dir_level
);

  logic btn_rise;
  logic dir_rise;

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_btn (
    .clk  (clk),
    .reset(reset),
    .raw  (push),
    .lvl  (btn_level),
    .rise (btn_rise)
  );

  debounce_ch #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
    .CNT_W(CNT_W)
  ) u_dir (
    .clk  (clk),
    .reset(reset),
    .raw  (updown),
    .lvl  (dir_level),
    .rise (dir_rise)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      reject    <= 1'b0;
    end else begin
      inc_pulse <= 1'b0;
      dec_pulse <= 1'b0;
      reject    <= 1'b0;
      if (btn_rise) begin
        unique case (1'b1)
          (dir_level && !full):  inc_pulse <= 1'b1;
          (!dir_level && !empty): dec_pulse <= 1'b1;
          default:                reject    <= 1'b1;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_queue_event_conditioner.sv
// Scoreboard bench for queue_event_conditioner at DEBOUNCE_CYCLES=4.
// Expected pulses are queued with their cycle when a press is driven.
module tb_queue_event_conditioner;

  localparam logic [2:0] K_INC = 3'b100;
  localparam logic [2:0] K_DEC = 3'b010;
  localparam logic [2:0] K_REJ = 3'b001;

  typedef struct {
    int         cyc;
    logic [2:0] kind;
  } exp_t;

  logic clk = 1'b0;
  logic reset, push, updown, full, empty;
  logic inc_pulse, dec_pulse, reject, btn_level, dir_level;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  queue_event_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .updown   (updown),
    .full     (full),
    .empty    (empty),
    .inc_pulse(inc_pulse),
    .dec_pulse(dec_pulse),
    .reject   (reject),
    .btn_level(btn_level),
    .dir_level(dir_level)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(logic [2:0] k, int hold);
    exp_t e;
    push   = 1'b1;
    e.cyc  = cyc + 6;
    e.kind = k;
    sb.push_back(e);
    step(hold);
  endtask

  task automatic release_btn(int n);
    push = 1'b0;
    step(n);
  endtask

  logic [2:0] o;
  exp_t       m;

  always @(negedge clk) begin
    o = {inc_pulse, dec_pulse, reject};
    if (o != 3'b000) begin
      chk("onehot", 32'($countones(o)), 1);
      if (sb.size() == 0) begin
        chk("unexpected", {29'd0, o}, 0);
      end else begin
        m = sb.pop_front();
        chk("kind", {29'd0, o}, {29'd0, m.kind});
        chk("when", cyc, m.cyc);
      end
    end else if (sb.size() > 0 && sb[0].cyc < cyc) begin
      m = sb.pop_front();
      chk("missing", 0, {29'd0, m.kind});
    end
  end

  initial begin
    int e;
    logic [0:4] bounce;
    reset  = 1'b0;
    push   = 1'b0;
    updown = 1'b1;
    full   = 1'b0;
    empty  = 1'b0;
    step(3);
    chk("rst_inc", inc_pulse, 0);
    chk("rst_dec", dec_pulse, 0);
    chk("rst_rej", reject, 0);
    chk("rst_btn", btn_level, 0);
    chk("rst_dir", dir_level, 0);
    reset = 1'b1;
    step(10);
    chk("dir_up", dir_level, 1);

    // clean press up, with press and release latency on btn_level
    e = cyc;
    press(K_INC, 5);
    chk("btn_pre", btn_level, 0);
    step(1);
    chk("btn_on", btn_level, 1);
    step(14);
    release_btn(5);
    chk("btn_hold", btn_level, 1);
    step(1);
    chk("btn_off", btn_level, 0);
    step(6);

    // bounce: short runs absorbed, final run yields one pulse
    bounce = 5'b10110;
    for (int i = 0; i < 5; i++) begin
      push = bounce[i];
      step(1);
    end
    press(K_INC, 15);
    release_btn(10);

    // blocked presses
    full = 1'b1;
    press(K_REJ, 12);
    release_btn(10);
    full   = 1'b0;
    updown = 1'b0;
    empty  = 1'b1;
    step(10);
    chk("dir_dn", dir_level, 0);
    press(K_REJ, 12);
    release_btn(10);
    empty = 1'b0;

    // direction switch while pressed has no effect
    updown = 1'b1;
    step(10);
    press(K_INC, 10);
    updown = 1'b0;
    step(12);
    chk("dir_sw", dir_level, 0);
    chk("btn_held", btn_level, 1);
    release_btn(10);
    press(K_DEC, 10);
    release_btn(10);

    // hold, short release, then full release
    press(K_DEC, 50);
    release_btn(3);
    push = 1'b1;
    step(20);
    chk("btn_short", btn_level, 1);
    release_btn(8);
    press(K_DEC, 12);
    release_btn(10);

    // reset during ARMING, push held through release
    push = 1'b1;
    step(3);
    reset = 1'b0;
    step(1);
    chk("mid_inc", inc_pulse, 0);
    chk("mid_dec", dec_pulse, 0);
    chk("mid_rej", reject, 0);
    chk("mid_btn", btn_level, 0);
    step(2);
    reset = 1'b1;
    press(K_DEC, 10);
    release_btn(10);

    step(5);
    chk("drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
